serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial addition sequencer built around the existing single-bit `half_adder` datapath. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It then steps one shared full-adder slice (two `half_adder` instances plus an OR gate) LSB-first for WIDTH cycles and presents the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits between any requester needing an N-bit add and the 1-bit adder cells, trading latency for area.

## Interface
- `WIDTH`, default 8: operand/sum width in bits; legal range 1..64.
- Clock: `i_clk` (single clock). Reset: `i_rst`, asynchronous and active-high.
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_valid`  in  1  request: operands valid.
- `o_ready`  out  1  controller can accept a request.
- `i_op_a`  in  WIDTH  operand A.
- `i_op_b`  in  WIDTH  operand B.
- `i_carry_in`  in  1  carry-in for bit 0.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_sum`  out  WIDTH  sum bits.
- `o_carry`  out  1  carry-out of MSB.
- `o_busy`  out  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: `o_ready`=1. On `i_valid`, capture A, B and carry-in, clear the bit counter, and go to RUN.
  - RUN: each cycle, feed `a[0]`, `b[0]` and the carry register to the slice. Shift A and B right by one. Shift the sum register right with the slice sum entering at bit WIDTH-1. Store the slice carry. Increment the counter. When counter == WIDTH-1 this cycle, go to DONE.
  - DONE: `o_valid`=1. Hold `o_sum`/`o_carry` stable. On `i_ready`, go to IDLE.
- Slice arithmetic:
  - s1 = a^b and c1 = a&b (half_adder #1).
  - sum = s1^cin and c2 = s1&cin (half_adder #2).
  - cout = c1|c2.
- The result equals `{o_carry, o_sum}` = A + B + cin, computed at full width+1 with no truncation.
- Counter width: max(1, clog2(WIDTH)). It never wraps inside an operation. It is cleared on accept.
- `o_ready` is decoded from state only; it does not depend on `i_ready`. No accept is possible in DONE, so an op is never overwritten.
- `i_valid` is ignored outside IDLE. `i_ready` is ignored outside DONE. Operand inputs are sampled only at the accept edge.
- `o_sum`/`o_carry` in IDLE and RUN show register contents but carry no meaning while `o_valid`=0.

## Timing
- Reset (async assert, any state): state=IDLE, `o_ready`=1, `o_valid`=0, `o_busy`=0, `o_sum`=0, `o_carry`=0, all operand, carry and counter registers cleared. An in-flight operation is discarded with no partial result emitted.
- Latency: request accepted at edge t, then RUN occupies edges t+1..t+WIDTH, and `o_valid` is high in the cycle after edge t+WIDTH.
- Result consumed at edge u (`o_valid`&`i_ready`): `o_ready`=1 in the cycle after u. The next accept is at earliest edge u+1.
- Sustained throughput: one add per WIDTH+2 cycles with `i_valid` and `i_ready` held high.
- WIDTH=1: RUN lasts exactly one cycle.
- Backpressure: DONE may persist indefinitely, and outputs must stay bit-stable throughout.

## Structure
- Shared package `serial_add_pkg`: state enum (IDLE, RUN, DONE), default WIDTH constant, and a counter-width function.
- Sub-module `serial_add_slice`: full-adder slice wrapping two `half_adder` instances plus the OR. It is purely combinational.
- Controller FSM, shift registers and counter live in `serial_add_ctrl`.

## Test plan
- WIDTH=8, A=0x5A, B=0x33, cin=0, `i_ready`=1 -> `o_sum`=0x8D, `o_carry`=0; `o_valid` 8 cycles after the accept edge.
- WIDTH=8, A=0xFF, B=0x01, cin=0 -> `o_sum`=0x00, `o_carry`=1. Then A=0xFF, B=0xFF, cin=1 -> `o_sum`=0xFF, `o_carry`=1.
- Backpressure: complete A=0x10, B=0x22. Hold `i_ready`=0 for 5 cycles while toggling `i_valid` with new operands -> `o_valid`=1, `o_sum`=0x32 stable, `o_ready`=0, new operands ignored. Raise `i_ready` -> `o_ready`=1 next cycle.
- Reset mid-RUN after 3 bits processed -> immediately `o_ready`=1, `o_valid`=0, `o_sum`=0x00, `o_carry`=0. A following add 0x01+0x01 returns 0x02.
- Back-to-back with `i_valid`/`i_ready` tied high -> accepts exactly every 10 cycles. 100 random operand pairs plus cin all match A+B+cin.
- WIDTH=1: A=1, B=1, cin=1 -> `o_sum`=1, `o_carry`=1, `o_valid` 1 cycle after accept.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width; a 1-bit operand still needs one counter bit.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell used as the serial datapath building block.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_add_slice.sv
// Combinational full-adder slice: two half adders chained, carries ORed.
module serial_add_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s1),
    .carry (c1)
  );

  half_adder u_ha1 (
    .a     (s1),
    .b     (cin),
    .sum   (sum),
    .carry (c2)
  );

  assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: accepts A/B/cin, steps one full-adder slice
// LSB-first for WIDTH cycles, then holds {carry, sum} until consumed.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_carry_in,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_busy
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_ins;
  logic [WIDTH-1:0]   sum_nxt;

  serial_add_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is aligned.
  always_comb begin
    sum_ins            = '0;
    sum_ins[WIDTH-1]   = slice_sum;
    sum_nxt            = (sum_q >> 1) | sum_ins;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            a_q     <= i_op_a;
            b_q     <= i_op_b;
            carry_q <= i_carry_in;
            cnt_q   <= '0;
            state   <= ST_RUN;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_nxt;
          carry_q <= slice_cout;
          // Counter stops at the last bit rather than wrapping.
          if (cnt_q == CNT_LAST) begin
            state   <= ST_DONE;
            o_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sum   = sum_q;
  assign o_carry = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 against an arithmetic model.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  logic       v8, rdy8, c8;
  logic [7:0] a8, b8;
  logic       ready8, valid8, carry8, busy8;
  logic [7:0] sum8;

  logic       v1, rdy1, c1;
  logic [0:0] a1, b1;
  logic       ready1, valid1, carry1, busy1;
  logic [0:0] sum1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (v8),
    .o_ready    (ready8),
    .i_op_a     (a8),
    .i_op_b     (b8),
    .i_carry_in (c8),
    .o_valid    (valid8),
    .i_ready    (rdy8),
    .o_sum      (sum8),
    .o_carry    (carry8),
    .o_busy     (busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (v1),
    .o_ready    (ready1),
    .i_op_a     (a1),
    .i_op_b     (b1),
    .i_carry_in (c1),
    .o_valid    (valid1),
    .i_ready    (rdy1),
    .o_sum      (sum1),
    .o_carry    (carry1),
    .o_busy     (busy1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full WIDTH=8 transaction, result consumed as soon as it appears.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
    int n;
    logic [8:0] exp;
    exp = 9'(a) + 9'(b) + 9'(c);
    n = 0;
    while (!ready8 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, ready8, 1);
    v8 = 1'b1; a8 = a; b8 = b; c8 = c;
    @(negedge clk);
    v8 = 1'b0;
    chk({tag, "_busy"}, {busy8, ready8}, 2'b10);
    n = 0;
    while (!valid8 && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_result"}, {carry8, sum8}, exp);
    rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
    chk({tag, "_after"}, {ready8, valid8, busy8}, 3'b100);
  endtask

  task automatic add1(input logic a, input logic b, input logic c, input string tag);
    int n;
    logic [1:0] exp;
    exp = 2'(a) + 2'(b) + 2'(c);
    n = 0;
    while (!ready1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, ready1, 1);
    v1 = 1'b1; a1 = a; b1 = b; c1 = c;
    @(negedge clk);
    v1 = 1'b0;
    n = 0;
    while (!valid1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_result"}, {carry1, sum1}, exp);
    rdy1 = 1'b1;
    @(negedge clk);
    rdy1 = 1'b0;
    chk({tag, "_after"}, {ready1, valid1, busy1}, 3'b100);
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] e;
    int acc, last, cyc, got;

    rst = 1'b1;
    v8 = 0; rdy8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v1 = 0; rdy1 = 0; a1 = 0; b1 = 0; c1 = 0;
    #1;
    chk("reset8", {ready8, valid8, busy8, carry8, sum8}, {4'b1000, 8'h00});
    chk("reset1", {ready1, valid1, busy1, carry1, sum1}, 5'b10000);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    add8(8'h5A, 8'h33, 1'b0, "add_5a_33");
    add8(8'hFF, 8'h01, 1'b0, "add_ff_01");
    add8(8'hFF, 8'hFF, 1'b1, "add_ff_ff_c");
    add8(8'h00, 8'h00, 1'b0, "add_zero");
    add8(8'h00, 8'h00, 1'b1, "add_cin_only");

    // Backpressure: result must hold while new requests are ignored.
    v8 = 1'b1; a8 = 8'h10; b8 = 8'h22; c8 = 1'b0;
    @(negedge clk);
    v8 = 1'b0;
    got = 0;
    while (!valid8 && got < 100) begin @(negedge clk); got++; end
    chk("bp_latency", got, 8);
    for (int i = 0; i < 5; i++) begin
      v8 = ~v8; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      @(negedge clk);
      chk("bp_hold", {valid8, ready8, busy8, carry8, sum8}, {4'b1010, 8'h32});
    end
    v8 = 1'b0; rdy8 = 1'b1;
    @(negedge clk);
    rdy8 = 1'b0;
    chk("bp_release", {ready8, valid8}, 2'b10);

    // Reset mid-RUN after three bits processed.
    v8 = 1'b1; a8 = 8'hAB; b8 = 8'h11; c8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy8, 1);
    rst = 1'b1;
    #1;
    chk("midrun_reset", {ready8, valid8, busy8, carry8, sum8}, {4'b1000, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    add8(8'h01, 8'h01, 1'b0, "post_reset");

    // Back-to-back with both handshakes held high; 100 random adds.
    rdy8 = 1'b1;
    acc = 0; last = -1; cyc = 0; got = 0;
    while ((acc < 100 || q.size() > 0) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (acc >= 100) v8 = 1'b0;
      if (valid8) begin
        e = q.pop_front();
        chk("b2b_result", {carry8, sum8}, e);
        got++;
      end
      if (ready8 && acc < 100) begin
        v8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom_range(0, 1));
        q.push_back(9'(a8) + 9'(b8) + 9'(c8));
        if (last >= 0) chk("b2b_interval", cyc - last, 10);
        last = cyc;
        acc++;
      end
    end
    chk("b2b_count", got, 100);
    @(negedge clk);
    rdy8 = 1'b0; v8 = 1'b0;
    chk("b2b_idle", {ready8, valid8}, 2'b10);

    // WIDTH=1: exhaustive over the three input bits.
    add1(1'b1, 1'b1, 1'b1, "w1_111");
    for (int k = 0; k < 8; k++) begin
      add1(k[2], k[1], k[0], "w1_combo");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
